// File: rtl/dual_fetch_unit_pkg.sv
// Shared fetch-path types.
//   XLEN_WIDTH    : architectural word width
//   FETCH_WIDTH   : instructions fetched per enqueue
//   fetch_entry_t : one queue slot, {pc, instr}
package common;
    localparam int XLEN_WIDTH  = 32;
    localparam int FETCH_WIDTH = 2;

    typedef struct packed {
        logic [XLEN_WIDTH-1:0] pc;
        logic [XLEN_WIDTH-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/dual_fetch_unit_queue.sv
// fetch_queue: circular instruction queue, 2-wide enqueue, 0..2 dequeue, flush.
//   clk, reset        : clock, synchronous active-high reset (clears storage too)
//   flush_i           : empty the queue; wins over enqueue and dequeue
//   enq_i             : write enq0_i at tail and enq1_i at tail+1 (caller guarantees room)
//   deq_cnt_i         : requested dequeue, 3 behaves as 2, clamped to current count
//   count_o           : registered occupancy 0..DEPTH
//   head0_o / head1_o : entries at head and head+1, straight from storage
module fetch_queue
    import common::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic                         enq_i,
    input  fetch_entry_t                 enq0_i,
    input  fetch_entry_t                 enq1_i,
    input  logic [1:0]                   deq_cnt_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output fetch_entry_t                 head0_o,
    output fetch_entry_t                 head1_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d, tail1;
    logic [CNT_W-1:0]   count_q, count_d, deq_req, deq_eff;

    // Pointer widths equal log2(DEPTH), so plain addition wraps modulo DEPTH.
    always_comb begin
        deq_req = (deq_cnt_i == 2'd0) ? CNT_W'(0) :
                  (deq_cnt_i == 2'd1) ? CNT_W'(1) : CNT_W'(2);
        deq_eff = (deq_req > count_q) ? count_q : deq_req;
        count_d = count_q - deq_eff + (enq_i ? CNT_W'(FETCH_WIDTH) : CNT_W'(0));
        head_d  = head_q + PTR_W'(deq_eff);
        tail1   = tail_q + PTR_W'(1);
        tail_d  = tail_q + PTR_W'(FETCH_WIDTH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            count_q <= count_d;
            if (enq_i) begin
                mem_q[tail_q] <= enq0_i;
                mem_q[tail1]  <= enq1_i;
                tail_q        <= tail_d;
            end
        end
    end

    assign count_o = count_q;
    assign head0_o = mem_q[head_q];
    assign head1_o = mem_q[head_q + PTR_W'(1)];
endmodule

// File: rtl/dual_fetch_unit.sv
// dual_fetch_unit: PC sequencing for a 2-wide fetch feeding an instruction queue.
//   clk, reset                  : clock, synchronous active-high reset
//   fetch_enable                : allow new fetches (PC frozen when low)
//   redirect_valid, redirect_pc : flush queue and restart fetch at redirect_pc
//   byte_address0/1             : combinational memory addresses PC, PC+4
//   read_data0/1                : combinational memory data for those addresses
//   deq_count                   : instructions consumed by decode this cycle
//   out_valid0/1, out_instr0/1, out_pc0/1 : queue head and head+1
module dual_fetch_unit
    import common::*;
#(
    parameter logic [XLEN_WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter int                    DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_enable,
    input  logic                  redirect_valid,
    input  logic [XLEN_WIDTH-1:0] redirect_pc,
    output logic [XLEN_WIDTH-1:0] byte_address0,
    output logic [XLEN_WIDTH-1:0] byte_address1,
    input  logic [XLEN_WIDTH-1:0] read_data0,
    input  logic [XLEN_WIDTH-1:0] read_data1,
    input  logic [1:0]            deq_count,
    output logic                  out_valid0,
    output logic                  out_valid1,
    output logic [XLEN_WIDTH-1:0] out_instr0,
    output logic [XLEN_WIDTH-1:0] out_instr1,
    output logic [XLEN_WIDTH-1:0] out_pc0,
    output logic [XLEN_WIDTH-1:0] out_pc1
);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [XLEN_WIDTH-1:0] pc_q;
    logic [CNT_W-1:0]      count;
    logic                  enq;
    fetch_entry_t          head0, head1;
    logic                  unused_rpc_lsbs;

    assign unused_rpc_lsbs = ^redirect_pc[1:0];

    // Room check uses the registered count only: a same-cycle dequeue does not
    // free space for this cycle's enqueue.
    assign enq = fetch_enable && !redirect_valid && (count <= CNT_W'(DEPTH-2));

    assign byte_address0 = pc_q;
    assign byte_address1 = pc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (reset)               pc_q <= {RESET_PC[XLEN_WIDTH-1:2], 2'b00};
        else if (redirect_valid) pc_q <= {redirect_pc[XLEN_WIDTH-1:2], 2'b00};
        else if (enq)            pc_q <= pc_q + 32'd8;
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush_i   (redirect_valid),
        .enq_i     (enq),
        .enq0_i    ('{pc: pc_q,         instr: read_data0}),
        .enq1_i    ('{pc: byte_address1, instr: read_data1}),
        .deq_cnt_i (deq_count),
        .count_o   (count),
        .head0_o   (head0),
        .head1_o   (head1)
    );

    assign out_valid0 = (count != '0);
    assign out_valid1 = (count >= CNT_W'(2));
    assign out_instr0 = head0.instr;
    assign out_instr1 = head1.instr;
    assign out_pc0    = head0.pc;
    assign out_pc1    = head1.pc;
endmodule

// File: tb/tb_dual_fetch_unit.sv
module tb_dual_fetch_unit;
    localparam int DEPTH = 4;

    logic        clk = 0;
    logic        reset, fetch_enable, redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  deq_count;

    logic [31:0] ba0, ba1, rd0, rd1, instr0, instr1, pc0, pc1;
    logic        v0, v1;
    logic [31:0] b_ba0, b_ba1, b_rd0, b_rd1, b_instr0, b_instr1, b_pc0, b_pc1;
    logic        b_v0, b_v1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    assign rd0   = mem(ba0);
    assign rd1   = mem(ba1);
    assign b_rd0 = mem(b_ba0);
    assign b_rd1 = mem(b_ba1);

    dual_fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .fetch_enable(fetch_enable),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .byte_address0(ba0), .byte_address1(ba1),
        .read_data0(rd0), .read_data1(rd1), .deq_count(deq_count),
        .out_valid0(v0), .out_valid1(v1),
        .out_instr0(instr0), .out_instr1(instr1), .out_pc0(pc0), .out_pc1(pc1)
    );

    // Second instance exercises a reset PC that wraps past 2^32.
    dual_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .reset(reset), .fetch_enable(fetch_enable),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .byte_address0(b_ba0), .byte_address1(b_ba1),
        .read_data0(b_rd0), .read_data1(b_rd1), .deq_count(deq_count),
        .out_valid0(b_v0), .out_valid1(b_v1),
        .out_instr0(b_instr0), .out_instr1(b_instr1), .out_pc0(b_pc0), .out_pc1(b_pc1)
    );

    // Reference model: a plain queue of fetched {pc, instr} plus a fetch PC.
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t        mq[$];
    logic [31:0] mpc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic fe, input logic rv,
                              input logic [31:0] rpc, input logic [1:0] dq);
        int n;
        bit room;
        if (r) begin
            mq.delete();
            mpc = 32'h0;
        end else if (rv) begin
            mq.delete();
            mpc = rpc & ~32'h3;
        end else begin
            room = (mq.size() <= DEPTH - 2);
            n = (dq >= 2) ? 2 : int'(dq);
            if (n > mq.size()) n = mq.size();
            repeat (n) void'(mq.pop_front());
            if (fe && room) begin
                mq.push_back('{mpc, mem(mpc)});
                mq.push_back('{mpc + 32'd4, mem(mpc + 32'd4)});
                mpc = mpc + 32'd8;
            end
        end
    endtask

    task automatic model_cmp(input string tag);
        chk({tag, ".v0"}, 32'(v0), 32'(mq.size() >= 1));
        chk({tag, ".v1"}, 32'(v1), 32'(mq.size() >= 2));
        chk({tag, ".ba0"}, ba0, mpc);
        chk({tag, ".ba1"}, ba1, mpc + 32'd4);
        if (mq.size() >= 1) begin
            chk({tag, ".pc0"}, pc0, mq[0].pc);
            chk({tag, ".in0"}, instr0, mq[0].instr);
        end
        if (mq.size() >= 2) begin
            chk({tag, ".pc1"}, pc1, mq[1].pc);
            chk({tag, ".in1"}, instr1, mq[1].instr);
        end
    endtask

    task automatic step(input logic r, input logic fe, input logic rv,
                        input logic [31:0] rpc, input logic [1:0] dq, input string tag);
        @(negedge clk);
        reset = r; fetch_enable = fe; redirect_valid = rv; redirect_pc = rpc; deq_count = dq;
        @(posedge clk);
        model_edge(r, fe, rv, rpc, dq);
        #1;
        model_cmp(tag);
    endtask

    typedef struct {
        logic        rst, fe, rv;
        logic [31:0] rpc;
        logic [1:0]  dq;
        logic        ev0, ev1;
        logic        cpc;
        logic [31:0] epc0, epc1;
        logic        cin;
        logic [31:0] ein0, ein1;
        logic [31:0] eba0;
    } vec_t;

    vec_t vt[20];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; fetch_enable = 0; redirect_valid = 0; redirect_pc = 0; deq_count = 0;
        mpc = 0;

        //          rst fe rv rpc         dq  v0 v1 cpc pc0          pc1          cin in0           in1           ba0
        vt[0]  = '{1, 1, 1, 32'h44,     0, 0, 0, 1, 32'h0,       32'h0,       1, 32'h0,        32'h0,        32'h0};
        vt[1]  = '{0, 1, 0, 32'h0,      0, 1, 1, 1, 32'h0,       32'h4,       1, 32'h1000_0000, 32'h1000_0001, 32'h8};
        vt[2]  = '{0, 1, 0, 32'h0,      0, 1, 1, 1, 32'h0,       32'h4,       1, 32'h1000_0000, 32'h1000_0001, 32'h10};
        vt[3]  = '{0, 1, 0, 32'h0,      0, 1, 1, 1, 32'h0,       32'h4,       0, 32'h0,        32'h0,        32'h10};
        vt[4]  = '{0, 1, 0, 32'h0,      1, 1, 1, 1, 32'h4,       32'h8,       1, 32'h1000_0001, 32'h1000_0002, 32'h10};
        vt[5]  = '{0, 1, 0, 32'h0,      1, 1, 1, 1, 32'h8,       32'hC,       1, 32'h1000_0002, 32'h1000_0003, 32'h10};
        vt[6]  = '{0, 1, 0, 32'h0,      0, 1, 1, 1, 32'h8,       32'hC,       0, 32'h0,        32'h0,        32'h18};
        vt[7]  = '{0, 1, 1, 32'h43,     2, 0, 0, 0, 32'h0,       32'h0,       0, 32'h0,        32'h0,        32'h40};
        vt[8]  = '{0, 1, 0, 32'h0,      0, 1, 1, 1, 32'h40,      32'h44,      1, 32'h1000_0010, 32'h1000_0011, 32'h48};
        vt[9]  = '{0, 1, 0, 32'h0,      2, 1, 1, 1, 32'h48,      32'h4C,      1, 32'h1000_0012, 32'h1000_0013, 32'h50};
        vt[10] = '{0, 1, 0, 32'h0,      2, 1, 1, 1, 32'h50,      32'h54,      0, 32'h0,        32'h0,        32'h58};
        vt[11] = '{0, 0, 0, 32'h0,      3, 0, 0, 0, 32'h0,       32'h0,       0, 32'h0,        32'h0,        32'h58};
        vt[12] = '{0, 1, 0, 32'h0,      0, 1, 1, 1, 32'h58,      32'h5C,      0, 32'h0,        32'h0,        32'h60};
        vt[13] = '{0, 0, 0, 32'h0,      1, 1, 0, 1, 32'h5C,      32'h0,       0, 32'h0,        32'h0,        32'h60};
        vt[14] = '{0, 0, 0, 32'h0,      3, 0, 0, 0, 32'h0,       32'h0,       0, 32'h0,        32'h0,        32'h60};
        vt[15] = '{0, 0, 0, 32'h0,      0, 0, 0, 0, 32'h0,       32'h0,       0, 32'h0,        32'h0,        32'h60};
        vt[16] = '{0, 1, 0, 32'h0,      0, 1, 1, 1, 32'h60,      32'h64,      0, 32'h0,        32'h0,        32'h68};
        vt[17] = '{0, 1, 0, 32'h0,      1, 1, 1, 1, 32'h64,      32'h68,      0, 32'h0,        32'h0,        32'h70};
        vt[18] = '{1, 1, 1, 32'h80,     2, 0, 0, 1, 32'h0,       32'h0,       1, 32'h0,        32'h0,        32'h0};
        vt[19] = '{0, 1, 0, 32'h0,      0, 1, 1, 1, 32'h0,       32'h4,       1, 32'h1000_0000, 32'h1000_0001, 32'h8};

        for (int i = 0; i < 20; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            step(vt[i].rst, vt[i].fe, vt[i].rv, vt[i].rpc, vt[i].dq, t);
            chk({t, ".tv0"}, 32'(v0), 32'(vt[i].ev0));
            chk({t, ".tv1"}, 32'(v1), 32'(vt[i].ev1));
            chk({t, ".tba0"}, ba0, vt[i].eba0);
            if (vt[i].cpc) begin
                chk({t, ".tpc0"}, pc0, vt[i].epc0);
                if (vt[i].ev1 || vt[i].rst) chk({t, ".tpc1"}, pc1, vt[i].epc1);
            end
            if (vt[i].cin) begin
                chk({t, ".tin0"}, instr0, vt[i].ein0);
                chk({t, ".tin1"}, instr1, vt[i].ein1);
            end
            // Wrapping instance shares the stimulus; check its early pairs.
            if (i == 0) begin
                chk("wrap.ba0", b_ba0, 32'hFFFF_FFF8);
                chk("wrap.ba1", b_ba1, 32'hFFFF_FFFC);
            end
            if (i == 1) begin
                chk("wrap.pc0", b_pc0, 32'hFFFF_FFF8);
                chk("wrap.pc1", b_pc1, 32'hFFFF_FFFC);
                chk("wrap.ba0n", b_ba0, 32'h0);
            end
            if (i == 5) begin
                chk("wrap.pair2a", b_pc0, 32'h0);
                chk("wrap.pair2b", b_pc1, 32'h4);
                chk("wrap.in2a", b_instr0, 32'h1000_0000);
            end
        end

        // Steady stream: one prime cycle, then two in / two out every cycle.
        step(1, 0, 0, 0, 0, "ss.rst");
        step(0, 1, 0, 0, 0, "ss.prime");
        for (int k = 1; k <= 10; k++) begin
            step(0, 1, 0, 0, 2, $sformatf("ss%0d", k));
            chk($sformatf("ss%0d.pc0", k), pc0, 32'(8 * k));
            chk($sformatf("ss%0d.vv", k), 32'({v0, v1}), 32'h3);
        end

        // Reset for one cycle with three entries queued.
        step(0, 1, 0, 0, 0, "mr.fill");
        step(0, 0, 0, 0, 1, "mr.deq");
        step(1, 1, 0, 0, 0, "mr.rst");
        chk("mr.vv", 32'({v0, v1}), 32'h0);
        chk("mr.in0", instr0, 32'h0);
        chk("mr.pc1", pc1, 32'h0);
        chk("mr.ba1", ba1, 32'h4);
        step(0, 1, 0, 0, 0, "mr.restart");
        chk("mr.rpc0", pc0, 32'h0);

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            logic r, fe, rv;
            logic [31:0] rpc;
            logic [1:0] dq;
            r   = ($urandom_range(99) < 1);
            rv  = ($urandom_range(99) < 4);
            fe  = ($urandom_range(99) < 75);
            rpc = $urandom;
            dq  = 2'($urandom_range(3));
            step(r, fe, rv, rpc, dq, $sformatf("rnd%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dual_fetch_unit.md
DUAL_FETCH_UNIT -- requirements
Module: dual_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset (bits [1:0] forced to 0).
REQ-002 SHALL have parameter DEPTH, default 4, instruction-queue entries; a power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 fetch_enable  input  1  permits new fetches.
REQ-006 redirect_valid  input  1  branch/jump redirect; flushes the queue.
REQ-007 redirect_pc  input  XLEN_WIDTH  new fetch PC; bits [1:0] ignored.
REQ-008 byte_address0  output  XLEN_WIDTH  program-memory read address, slot 0; equals the PC register.
REQ-009 byte_address1  output  XLEN_WIDTH  program-memory read address, slot 1; equals PC+4 mod 2^32.
REQ-010 read_data0 / read_data1  input  XLEN_WIDTH  combinational program-memory data for byte_address0 / byte_address1.
REQ-011 deq_count  input  2  number of instructions decode consumes this cycle (0, 1 or 2).
REQ-012 out_valid0 / out_valid1  output  1  queue holds at least 1 / at least 2 entries.
REQ-013 out_instr0 / out_instr1  output  XLEN_WIDTH  instruction at queue head / head+1.
REQ-014 out_pc0 / out_pc1  output  XLEN_WIDTH  byte PC of out_instr0 / out_instr1.

Function
REQ-015 SHALL hold a circular queue of DEPTH entries {pc, instr}, with head pointer, tail pointer and count (0..DEPTH).
REQ-016 byte_address0/1 SHALL be purely combinational from the PC register; read data is sampled in the same cycle.
REQ-017 Enqueue condition: fetch_enable=1, redirect_valid=0 and registered count <= DEPTH-2 (ignoring same-cycle dequeue).
REQ-018 On enqueue: write {PC, read_data0} at tail and {PC+4, read_data1} at tail+1; tail += 2; PC += 8 mod 2^32.
REQ-019 Effective dequeue = min(deq_count, count); deq_count=3 is treated as 2; head advances by the effective dequeue.
REQ-020 count_next = count - effective dequeue + (2 if enqueue, else 0).
REQ-021 Pointers SHALL wrap modulo DEPTH.
REQ-022 Outputs SHALL be driven directly from queue registers, so an instruction is visible the cycle after its fetch (latency 1).
REQ-023 On redirect_valid=1: count, head and tail go to 0, PC loads redirect_pc with [1:0]=0, and no enqueue occurs; redirect overrides both dequeue and enqueue in that cycle.
REQ-024 Fetch resumes at redirect_pc on the cycle after a redirect; out_valid0/1 are 0 during that cycle.
REQ-025 When an out_validN is 0, its out_instrN/out_pcN are don't-care for consumers and SHALL NOT be relied on.
REQ-026 fetch_enable=0 SHALL freeze the PC; dequeue continues.

Reset
REQ-027 While reset=1 at a clock edge: PC=RESET_PC, head=tail=count=0, all queue entries={0,0}, and redirect and fetch inputs are ignored.
REQ-028 After reset: out_valid0/1=0, out_instr0/1=0, out_pc0/1=0, byte_address0=RESET_PC, byte_address1=RESET_PC+4.
REQ-029 Reset asserted mid-operation SHALL discard all queued instructions, with no partial enqueue.

Structure
REQ-030 XLEN_WIDTH, fetch_entry_t {pc, instr} and FETCH_WIDTH=2 SHALL live in package common.
REQ-031 Queue storage and pointers SHALL be one sub-module, fetch_queue (2-wide enqueue, 0-2 dequeue, flush); PC logic stays in dual_fetch_unit.

Verification
REQ-032 Memory word k = 32'h1000_0000+k, RESET_PC=0, fetch_enable=1, deq_count=0.
- Edge 1 -> count 2, out_instr0=32'h1000_0000, out_pc1=4.
- Edge 2 -> count 4.
- Edge 3 -> count 4, byte_address0=32'h10.
REQ-033 Steady stream, deq_count=2 every cycle -> each cycle out_pc0 advances by 8 (0, 8, 0x10, ...) with out_valid0=out_valid1=1, and no gaps after the first cycle.
REQ-034 Full queue, deq_count=1 -> count 3, with no enqueue because 3 > DEPTH-2. Next cycle deq_count=1 -> count 2, then enqueue brings count to 4; out_pc order is monotonic, no duplicates or skips.
REQ-035 count=4, redirect_valid=1 with redirect_pc=32'h43 and deq_count=2 in the same cycle -> next cycle count=0, both valids 0, byte_address0=32'h40; following cycle out_pc0=32'h40, out_pc1=32'h44.
REQ-036 RESET_PC=32'hFFFF_FFF8 -> first pair pcs FFFF_FFF8/FFFF_FFFC, second pair 0/4. Separately, deq_count=3 with count=1 -> count 0 with no underflow.
REQ-037 Reset asserted for 1 cycle with count=3 -> next cycle all REQ-028 values hold, then fetch restarts at RESET_PC.
